phy_clk_sw_ctrl: RTL

- Break-before-make sequencer for the two gated clock sources that feed the PHY clock OR cell.
- Drives the gate enables for source 0 and source 1, so at most one source is ever ungated into the OR.
- A switch request runs this sequence: disable the current source, confirm it is off, wait a guard time, enable the new source, confirm it is on.
- Runs on the always-on control clock clk.

---
 rtl/phy_clk_pkg.sv | 21 ++
 rtl/phy_sync_bit.sv | 27 ++
 rtl/phy_clk_sw_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/phy_clk_pkg.sv
// Shared types and constants for the PHY clock-source switch sequencer.
// The state enum, counter width and reset-default source are used by the controller.
package phy_clk_pkg;

    localparam int   CNT_W        = 16;
    localparam logic CLK_SRC_DFLT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OFF_WAIT,
        ST_GUARD,
        ST_ON_WAIT,
        ST_ERR
    } sw_state_e;

    // The counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/phy_sync_bit.sv
// Multi-flop synchroniser for one asynchronous status bit.
// It has a synchronous active-high reset to 0.
module phy_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: the flop chain uses non-blocking assignments. Each stage then
    // samples the value its predecessor held before the edge, so the chain
    // does not collapse into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/phy_clk_sw_ctrl.sv
// Break-before-make sequencer for the two gated clock sources feeding the PHY clock OR.
// At most one gate enable is high at any time. A timeout on either ack parks both gates off.
module phy_clk_sw_ctrl
    import phy_clk_pkg::*;
#(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sel_req,
    input  logic ack0,
    input  logic ack1,
    output logic en0,
    output logic en1,
    output logic sel_cur,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sw_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tgt_q;
    logic             en0_q, en1_q, sel_cur_q, busy_q, done_q, err_q;

    logic s_ack0, s_ack1;
    logic s_ack_cur, s_ack_tgt;

    phy_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack0 (
        .clk (clk),
        .rst (rst),
        .d_i (ack0),
        .q_o (s_ack0)
    );

    phy_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack1 (
        .clk (clk),
        .rst (rst),
        .d_i (ack1),
        .q_o (s_ack1)
    );

    assign s_ack_cur = sel_cur_q ? s_ack1 : s_ack0;
    assign s_ack_tgt = tgt_q     ? s_ack1 : s_ack0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tgt_q     <= CLK_SRC_DFLT;
            en0_q     <= (CLK_SRC_DFLT == 1'b0);
            en1_q     <= (CLK_SRC_DFLT == 1'b1);
            sel_cur_q <= CLK_SRC_DFLT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_req != sel_cur_q) begin
                        // The idle enable is the current source's enable, so clearing both is the same as clearing it.
                        state_q <= ST_OFF_WAIT;
                        tgt_q   <= sel_req;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        en0_q   <= 1'b0;
                        en1_q   <= 1'b0;
                    end
                end
                ST_OFF_WAIT: begin
                    if (!s_ack_cur) begin
                        state_q <= ST_GUARD;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_sat_inc(cnt_q);
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_q <= ST_ON_WAIT;
                        cnt_q   <= '0;
                        en0_q   <= ~tgt_q;
                        en1_q   <= tgt_q;
                    end else begin
                        cnt_q <= cnt_sat_inc(cnt_q);
                    end
                end
                ST_ON_WAIT: begin
                    if (s_ack_tgt) begin
                        state_q   <= ST_IDLE;
                        sel_cur_q <= tgt_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        en0_q   <= 1'b0;
                        en1_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_sat_inc(cnt_q);
                    end
                end
                ST_ERR: begin
                    en0_q  <= 1'b0;
                    en1_q  <= 1'b0;
                    busy_q <= 1'b1;
                    err_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_ERR;
                    en0_q   <= 1'b0;
                    en1_q   <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign en0     = en0_q;
    assign en1     = en1_q;
    assign sel_cur = sel_cur_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
